// File: rtl/fractal_sync_rr_scheduler_if.sv
// Handshake bundle between the source request FIFOs, the round-robin scheduler and its consumer.
// The master modport is the scheduler's view; the slave modport is the surrounding environment's.
interface fractal_sync_rr_scheduler_if #(
    parameter int unsigned IN_PORTS  = 4,
    parameter int unsigned OUT_PORTS = 2,
    parameter type         elem_t    = logic
);
    logic [IN_PORTS-1:0]  empty_i;
    elem_t                element_i [IN_PORTS];
    logic [IN_PORTS-1:0]  pop_o;
    logic                 stall_i;
    logic [OUT_PORTS-1:0] valid_o;
    elem_t                element_o [OUT_PORTS];

    modport master (
        input  empty_i, element_i, stall_i,
        output pop_o, valid_o, element_o
    );

    modport slave (
        output empty_i, element_i, stall_i,
        input  pop_o, valid_o, element_o
    );
endinterface

// File: rtl/fractal_sync_rr_scheduler.sv
// Round-robin scheduler: drains up to OUT_PORTS heads per cycle from IN_PORTS FIFOs into
// registered output slots, with stall backpressure and a saturating grant counter.
module fractal_sync_rr_scheduler #(
    parameter int unsigned IN_PORTS  = 4,
    parameter int unsigned OUT_PORTS = 2,
    parameter type         elem_t    = logic,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    fractal_sync_rr_scheduler_if.master bus_io,
    input  logic                    clear_cnt_i,
    output logic [CNT_WIDTH-1:0]    grant_cnt_o
);
    localparam int unsigned PtrW = $clog2(IN_PORTS);
    localparam int unsigned NgW  = $clog2(OUT_PORTS + 1);

    if (IN_PORTS < 2) begin : g_bad_in_ports
        $fatal(1, "fractal_sync_rr_scheduler: IN_PORTS must be >= 2");
    end
    if (OUT_PORTS < 1 || OUT_PORTS > IN_PORTS) begin : g_bad_out_ports
        $fatal(1, "fractal_sync_rr_scheduler: OUT_PORTS must be in 1..IN_PORTS");
    end

    function automatic logic [PtrW-1:0] wrap_add(logic [PtrW-1:0] base, int unsigned off);
        logic [PtrW:0] s;
        s = {1'b0, base} + (PtrW+1)'(off);
        if (s >= (PtrW+1)'(IN_PORTS)) s = s - (PtrW+1)'(IN_PORTS);
        return s[PtrW-1:0];
    endfunction

    logic [PtrW-1:0]      ptr_q, ptr_d;
    logic [OUT_PORTS-1:0] valid_q, valid_d;
    elem_t                element_q [OUT_PORTS];
    elem_t                element_d [OUT_PORTS];
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [PtrW-1:0]      scan_idx [IN_PORTS];
    logic [IN_PORTS-1:0]  grant;
    logic [OUT_PORTS-1:0] slot_hit;
    logic [PtrW-1:0]      slot_src [OUT_PORTS];
    logic [PtrW-1:0]      last_idx;
    logic [NgW-1:0]       ng;
    logic [NgW-1:0]       ng_eff;
    logic [CNT_WIDTH:0]   cnt_sum;

    always_comb begin
        for (int unsigned j = 0; j < IN_PORTS; j++) begin
            scan_idx[j] = wrap_add(ptr_q, j);
        end
    end

    // One lap starting at ptr_q; the k-th non-empty source found lands in slot k.
    always_comb begin
        grant    = '0;
        slot_hit = '0;
        last_idx = ptr_q;
        ng       = '0;
        for (int unsigned k = 0; k < OUT_PORTS; k++) slot_src[k] = '0;
        for (int unsigned j = 0; j < IN_PORTS; j++) begin
            if (!bus_io.empty_i[scan_idx[j]] && (ng < NgW'(OUT_PORTS))) begin
                grant[scan_idx[j]] = 1'b1;
                for (int unsigned k = 0; k < OUT_PORTS; k++) begin
                    if (ng == NgW'(k)) begin
                        slot_hit[k] = 1'b1;
                        slot_src[k] = scan_idx[j];
                    end
                end
                last_idx = scan_idx[j];
                ng       = ng + NgW'(1);
            end
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        for (int unsigned k = 0; k < OUT_PORTS; k++) element_d[k] = element_q[k];
        ng_eff  = bus_io.stall_i ? '0 : ng;
        if (!bus_io.stall_i) begin
            valid_d = slot_hit;
            for (int unsigned k = 0; k < OUT_PORTS; k++) begin
                element_d[k] = slot_hit[k] ? bus_io.element_i[slot_src[k]] : '0;
            end
            if (ng != '0) ptr_d = wrap_add(last_idx, 1);
        end
        cnt_sum = {1'b0, cnt_q} + (CNT_WIDTH+1)'(ng_eff);
        if (clear_cnt_i) begin
            cnt_d = '0;
        end else if (cnt_sum[CNT_WIDTH]) begin
            cnt_d = '1;
        end else begin
            cnt_d = cnt_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            valid_q <= '0;
            cnt_q   <= '0;
            for (int unsigned k = 0; k < OUT_PORTS; k++) element_q[k] <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int unsigned k = 0; k < OUT_PORTS; k++) element_q[k] <= element_d[k];
        end
    end

    // Pops are combinational but suppressed during reset so no FIFO head is lost.
    assign bus_io.pop_o     = (bus_io.stall_i || rst_i) ? '0 : grant;
    assign bus_io.valid_o   = valid_q;
    assign bus_io.element_o = element_q;
    assign grant_cnt_o      = cnt_q;
endmodule

// File: tb/tb_fractal_sync_rr_scheduler.sv
// Randomized and directed bench for the round-robin scheduler against a queue-based model.
module tb_fractal_sync_rr_scheduler;
    localparam int unsigned IN  = 4;
    localparam int unsigned OUT = 2;
    localparam int unsigned CW  = 4;
    typedef logic [7:0] elem_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic [CW-1:0] cnt;

    int unsigned errs   = 0;
    int unsigned checks = 0;

    fractal_sync_rr_scheduler_if #(.IN_PORTS(IN), .OUT_PORTS(OUT), .elem_t(elem_t)) bus ();

    fractal_sync_rr_scheduler #(
        .IN_PORTS (IN),
        .OUT_PORTS(OUT),
        .elem_t   (elem_t),
        .CNT_WIDTH(CW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus_io     (bus),
        .clear_cnt_i(clear),
        .grant_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    // Reference state
    int    m_ptr;
    bit    m_valid [OUT];
    elem_t m_elem  [OUT];
    int    m_cnt;
    int    gq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ptr = 0;
        m_cnt = 0;
        for (int k = 0; k < OUT; k++) begin
            m_valid[k] = 1'b0;
            m_elem[k]  = '0;
        end
    endfunction

    // Non-empty sources in rotated order starting at the pointer, first OUT of them.
    function automatic void model_grants();
        gq.delete();
        for (int j = 0; j < IN; j++) begin
            int i;
            i = (m_ptr + j) % IN;
            if (!bus.empty_i[i] && gq.size() < OUT) gq.push_back(i);
        end
    endfunction

    function automatic logic [IN-1:0] model_pop();
        logic [IN-1:0] p;
        p = '0;
        if (!bus.stall_i) foreach (gq[n]) p[gq[n]] = 1'b1;
        return p;
    endfunction

    function automatic void model_commit();
        int ng;
        ng = 0;
        if (!bus.stall_i) begin
            ng = gq.size();
            for (int k = 0; k < OUT; k++) begin
                m_valid[k] = (k < ng);
                m_elem[k]  = (k < ng) ? bus.element_i[gq[k]] : '0;
            end
            if (ng > 0) m_ptr = (gq[ng-1] + 1) % IN;
        end
        if (clear) m_cnt = 0;
        else       m_cnt = (m_cnt + ng > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + ng;
    endfunction

    task automatic check_outs();
        logic [OUT-1:0] ev;
        for (int k = 0; k < OUT; k++) ev[k] = m_valid[k];
        chk("valid", 32'(bus.valid_o), 32'(ev));
        for (int k = 0; k < OUT; k++) chk($sformatf("elem%0d", k), 32'(bus.element_o[k]),
                                          32'(m_elem[k]));
        chk("cnt", 32'(cnt), 32'(m_cnt));
    endtask

    // Called at a negedge; dir_pop < 0 skips the directed pop check.
    task automatic cycle(input logic [IN-1:0] emp, input logic stl, input logic clr,
                         input int dir_pop);
        bus.empty_i = emp;
        bus.stall_i = stl;
        clear       = clr;
        for (int i = 0; i < IN; i++) bus.element_i[i] = elem_t'($urandom);
        #1;
        model_grants();
        chk("pop", 32'(bus.pop_o), 32'(model_pop()));
        if (dir_pop >= 0) chk("dir_pop", 32'(bus.pop_o), 32'(dir_pop));
        @(posedge clk);
        model_commit();
        #1;
        check_outs();
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        clear       = 1'b0;
        bus.empty_i = '1;
        bus.stall_i = 1'b0;
        for (int i = 0; i < IN; i++) bus.element_i[i] = '0;
        model_reset();
        #1;
        chk("rst_pop", 32'(bus.pop_o), 32'h0);
        check_outs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // T1: full lap in two cycles, pointer wraps back to 0
        cycle(4'b0000, 1'b0, 1'b0, 4'b0011);
        chk("t1_valid", 32'(bus.valid_o), 32'h3);
        cycle(4'b0000, 1'b0, 1'b0, 4'b1100);
        // T2: ptr -> 2 via FIFO1, then only FIFO3 pending
        cycle(4'b1101, 1'b0, 1'b0, 4'b0010);
        cycle(4'b0111, 1'b0, 1'b0, 4'b1000);
        chk("t2_valid", 32'(bus.valid_o), 32'h1);
        // T3: ptr -> 3 via FIFO2, then FIFOs 3 and 0 scanned in wrap order
        cycle(4'b1011, 1'b0, 1'b0, 4'b0100);
        cycle(4'b0110, 1'b0, 1'b0, 4'b1001);
        // T4: stall holds everything, then resumes
        for (int n = 0; n < 3; n++) cycle(4'b0000, 1'b1, 1'b0, 0);
        cycle(4'b0000, 1'b0, 1'b0, -1);
        // T5: saturate the 4-bit counter, then clear wins over increment
        cycle(4'b0000, 1'b0, 1'b1, -1);
        for (int n = 0; n < 8; n++) cycle(4'b0000, 1'b0, 1'b0, -1);
        chk("t5_sat", 32'(cnt), 32'd15);
        cycle(4'b0000, 1'b0, 1'b1, -1);
        chk("t5_clr", 32'(cnt), 32'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cycle(IN'($urandom), ($urandom_range(3) == 0), ($urandom_range(15) == 0), -1);
        end

        // T6: reset mid-stream with slots valid
        cycle(4'b0000, 1'b0, 1'b0, -1);
        bus.empty_i = '0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("t6_pop", 32'(bus.pop_o), 32'h0);
        check_outs();
        @(negedge clk);
        rst = 1'b0;
        cycle(4'b0000, 1'b0, 1'b0, 4'b0011);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
